spi_debug_bus_bridge: RTL

Sys_clk-domain stage directly downstream of the SPI debug interface. Consumes its byte-wide register writes (wr/waddr/wdata) and assembles them into 32-bit address and data words. A write to the top data byte commits a 64-bit command into a small FIFO. A req/ack bus master drains that FIFO into the system bus, so debug SPI traffic can poke arbitrary 32-bit bus locations without stalling the byte stream.

---
 rtl/spi_debug_bus_pkg.sv | 45 ++++
 rtl/dbg_cmd_fifo.sv | 67 ++++++
 rtl/spi_debug_bus_bridge.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/spi_debug_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_debug_bus_pkg
// Description : Shared register map, FSM states and command type for the
//               SPI debug-to-system-bus bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_debug_bus_pkg;

    // Debug register byte offsets (little-endian words)
    localparam logic [7:0] REG_ADDR0 = 8'h00;
    localparam logic [7:0] REG_DATA0 = 8'h04;
    localparam logic [7:0] REG_DATA3 = 8'h07;
    localparam logic [7:0] REG_CTRL  = 8'h08;

    // CTRL register bit positions
    localparam int CTRL_AUTOINC_BIT = 0;
    localparam int CTRL_FLUSH_BIT   = 1;

    // Bus master states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } bus_state_t;

    // One queued bus write
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } dbg_cmd_t;

    // Replace byte idx of a 32-bit word
    function automatic logic [31:0] byte_merge(
        input logic [31:0] word,
        input logic [1:0]  idx,
        input logic [7:0]  new_byte
    );
        logic [31:0] merged;
        merged = word;
        merged[{idx, 3'b000} +: 8] = new_byte;
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dbg_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dbg_cmd_fifo
// Description : Synchronous command FIFO (64-bit entries). A push on a full
//               FIFO is accepted when a pop happens on the same edge. Flush
//               discards every queued entry; an entry popped on the flush edge
//               has already been handed to the bus side and is unaffected.
// Revision    : 1.0 - initial release
// ============================================================================
module dbg_cmd_fifo
    import spi_debug_bus_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_push,
    input  dbg_cmd_t i_push_cmd,
    input  logic     i_pop,
    input  logic     i_flush_keep_head,
    output logic     o_full,
    output logic     o_empty,
    output dbg_cmd_t o_head
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);

    // Pointers carry one wrap bit so full and empty are distinguishable
    logic [c_PTR_W:0] r_wr_ptr;
    logic [c_PTR_W:0] r_rd_ptr;
    dbg_cmd_t         r_mem [FIFO_DEPTH];

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                       (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign w_do_pop  = i_pop & ~w_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop) & ~i_flush_keep_head;

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_head  = r_mem[r_rd_ptr[c_PTR_W-1:0]];

    // Pointer maintenance: flush collapses the read pointer onto the write pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush_keep_head) begin
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage array write port (contents need no reset, pointers gate validity)
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_PTR_W-1:0]] <= i_push_cmd;
    end

endmodule
`default_nettype wire

// File: rtl/spi_debug_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : spi_debug_bus_bridge
// Description : Assembles byte-wide SPI debug register writes into 32-bit
//               address/data words, queues committed commands and replays
//               them as req/ack bus writes.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_debug_bus_bridge
    import spi_debug_bus_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst_i,
    input  logic        sys_wr_i,
    input  logic [7:0]  sys_waddr_i,
    input  logic [7:0]  sys_wdata_i,
    output logic        bus_req_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    output logic        busy_o,
    output logic [7:0]  drop_count_o
);

    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic        r_autoinc;
    logic [7:0]  r_drop_count;

    bus_state_t  r_state;
    logic        r_bus_req;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;

    logic        w_wr_addr;
    logic        w_wr_data;
    logic        w_commit;
    logic        w_wr_ctrl;
    logic        w_flush;
    logic [31:0] w_data_next;
    dbg_cmd_t    w_push_cmd;
    logic        w_pop;
    logic        w_drop;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    dbg_cmd_t    w_fifo_head;

    // Register decode
    assign w_wr_addr   = sys_wr_i && (sys_waddr_i[7:2] == REG_ADDR0[7:2]);
    assign w_wr_data   = sys_wr_i && (sys_waddr_i[7:2] == REG_DATA0[7:2]);
    assign w_commit    = sys_wr_i && (sys_waddr_i == REG_DATA3);
    assign w_wr_ctrl   = sys_wr_i && (sys_waddr_i == REG_CTRL);
    assign w_flush     = w_wr_ctrl && sys_wdata_i[CTRL_FLUSH_BIT];
    assign w_data_next = byte_merge(r_data, sys_waddr_i[1:0], sys_wdata_i);

    // The committed entry carries the pre-increment address and the new top byte
    assign w_push_cmd = '{addr: r_addr, data: w_data_next};

    // The head leaves the FIFO when it is latched onto the bus, so the
    // in-flight write occupies the bus registers rather than a FIFO slot
    assign w_pop  = (r_state == ST_IDLE) && !w_fifo_empty;
    assign w_drop = w_commit && w_fifo_full && !w_pop;

    dbg_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk               (sys_clk),
        .rst               (sys_rst_i),
        .i_push            (w_commit),
        .i_push_cmd        (w_push_cmd),
        .i_pop             (w_pop),
        .i_flush_keep_head (w_flush),
        .o_full            (w_fifo_full),
        .o_empty           (w_fifo_empty),
        .o_head            (w_fifo_head)
    );

    // Debug-visible ADDR/DATA/CTRL registers, including address auto-increment
    always_ff @(posedge sys_clk or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_addr    <= '0;
            r_data    <= '0;
            r_autoinc <= 1'b0;
        end else begin
            if (w_wr_addr) r_addr <= byte_merge(r_addr, sys_waddr_i[1:0], sys_wdata_i);
            if (w_wr_data) r_data <= w_data_next;
            if (w_commit && r_autoinc) r_addr <= r_addr + 32'd4;
            if (w_wr_ctrl) r_autoinc <= sys_wdata_i[CTRL_AUTOINC_BIT];
        end
    end

    // Saturating count of commits rejected because the FIFO was full
    always_ff @(posedge sys_clk or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 8'd1;
        end
    end

    // Bus master: latch the FIFO head, hold the request until acknowledged
    always_ff @(posedge sys_clk or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_state     <= ST_IDLE;
            r_bus_req   <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_bus_addr  <= w_fifo_head.addr;
                        r_bus_wdata <= w_fifo_head.data;
                        r_bus_req   <= 1'b1;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus_ack_i) begin
                        r_bus_req <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_bus_req <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_req_o    = r_bus_req;
    assign bus_addr_o   = r_bus_addr;
    assign bus_wdata_o  = r_bus_wdata;
    assign busy_o       = r_bus_req | ~w_fifo_empty;
    assign drop_count_o = r_drop_count;

endmodule
`default_nettype wire
